// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / 3x3 window out bundle for window_3x3_gen.
// master drives the pixel stream, slave is the window generator.
interface window_3x3_gen_if #(
  parameter int PIX_W = 24
);
  logic [PIX_W-1:0]   in_Pixel;
  logic               in_Valid;
  logic               in_Sof;
  logic [3*PIX_W-1:0] out_M0;
  logic [3*PIX_W-1:0] out_M1;
  logic [3*PIX_W-1:0] out_M2;
  logic [PIX_W-1:0]   out_Center;
  logic               out_Valid;
  logic               out_Frame_Done;

  modport master (
    output in_Pixel, in_Valid, in_Sof,
    input  out_M0, out_M1, out_M2,
    input  out_Center, out_Valid, out_Frame_Done
  );

  modport slave (
    input  in_Pixel, in_Valid, in_Sof,
    output out_M0, out_M1, out_M2,
    output out_Center, out_Valid, out_Frame_Done
  );
endinterface

// File: rtl/window_3x3_gen.sv
// Sliding 3x3 neighbourhood from a raster RGB stream using two
// line buffers; one window per accepted pixel once inside the image.
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_W      = 24
) (
  input logic              clk,
  input logic              rst_n,
  window_3x3_gen_if.slave  bus
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int RW = 3 * PIX_W;
  localparam logic [XW-1:0] XMAX = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(IMG_HEIGHT - 1);

  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;
  logic [XW-1:0]    cx;
  logic [YW-1:0]    cy;
  logic [PIX_W-1:0] lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;
  logic [RW-1:0]    m0_q;
  logic [RW-1:0]    m1_q;
  logic [RW-1:0]    m2_q;
  logic             vld_q;
  logic             done_q;
  logic             win_ok;
  logic             last_px;

  // Sof restarts the frame on the very pixel that carries it
  always_comb begin
    cx      = bus.in_Sof ? '0 : x_q;
    cy      = bus.in_Sof ? '0 : y_q;
    lb0_rd  = lb0[cx];
    lb1_rd  = lb1[cx];
    win_ok  = (cx >= XW'(2)) && (cy >= YW'(2));
    last_px = (cx == XMAX) && (cy == YMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      m0_q   <= '0;
      m1_q   <= '0;
      m2_q   <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vld_q  <= bus.in_Valid && win_ok;
      done_q <= bus.in_Valid && last_px;
      if (bus.in_Valid) begin
        m0_q <= {lb1_rd, m0_q[RW-1:PIX_W]};
        m1_q <= {lb0_rd, m1_q[RW-1:PIX_W]};
        m2_q <= {bus.in_Pixel, m2_q[RW-1:PIX_W]};
        if (cx == XMAX) begin
          x_q <= '0;
          y_q <= (cy == YMAX) ? '0 : cy + 1'b1;
        end else begin
          x_q <= cx + 1'b1;
          y_q <= cy;
        end
      end
    end
  end

  // Line RAM: no reset, stale rows are masked by the y>=2 gate
  always_ff @(posedge clk) begin
    if (bus.in_Valid) begin
      lb1[cx] <= lb0_rd;
      lb0[cx] <= bus.in_Pixel;
    end
  end

  assign bus.out_M0         = m0_q;
  assign bus.out_M1         = m1_q;
  assign bus.out_M2         = m2_q;
  assign bus.out_Center     = m1_q[2*PIX_W-1:PIX_W];
  assign bus.out_Valid      = vld_q;
  assign bus.out_Frame_Done = done_q;
endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
Builds a sliding 3x3 pixel neighbourhood from a raster-order 24-bit RGB pixel stream, using two internal line buffers. It sits directly upstream of the edge-detection/convolution stage and drives that stage's three 72-bit row inputs plus a centre pixel for pass-through. One window is produced per accepted input pixel once the window is fully inside the image. Single clock domain.

Parameters:
IMG_WIDTH, 640, active pixels per line (>=3)
IMG_HEIGHT, 480, active lines per frame (>=3)
PIX_W, 24, bits per pixel (fixed 24 for downstream compatibility)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
in_Pixel  in  24  input pixel, raster order
in_Valid  in  1  in_Pixel accepted on this edge when 1; no backpressure
in_Sof  in  1  qualified by in_Valid; marks pixel (0,0) of a frame
out_M0  out  72  top row of window (oldest line)
out_M1  out  72  middle row of window
out_M2  out  72  bottom row of window (current line)
out_Center  out  24  window centre pixel, equals out_M1[47:24]
out_Valid  out  1  window outputs valid this cycle
out_Frame_Done  out  1  one-cycle pulse after last pixel of frame accepted

Behaviour:
- Reset (async, rst_n=0): x=0, y=0, window regs=0, out_M0/M1/M2=0, out_Center=0, out_Valid=0, out_Frame_Done=0. Line-buffer RAM not reset; content is don't-care.
- Row packing: bits [23:0]=left (oldest) column, [47:24]=middle, [71:48]=right (newest). For centre (cx,cy): out_M0 = {P(cx+1,cy-1), P(cx,cy-1), P(cx-1,cy-1)}; same for M1 at cy, M2 at cy+1.
- Line buffers: LB0 holds line y-1, LB1 line y-2; each IMG_WIDTH x 24, addressed by x, combinational read (distributed RAM/regs).
- Per accepted pixel (in_Valid=1): column shift: M0 <= {LB1[x], M0[71:24]}, M1 <= {LB0[x], M1[71:24]}, M2 <= {in_Pixel, M2[71:24]}; LB1[x] <= LB0[x]; LB0[x] <= in_Pixel.
- Coordinate used is (0,0) if in_Sof=1, otherwise the current (x,y). Counter advance after accept: x+1; at x=IMG_WIDTH-1, x<=0 and y+1; at y=IMG_HEIGHT-1 with x=IMG_WIDTH-1, y<=0 (implicit next frame).
- out_Valid <= in_Valid && x>=2 && y>=2, using the coordinate of the accepted pixel. Latency: 1 clk from accepting the window's bottom-right pixel to out_Valid. No windows at x<2 or y<2. Border pixels are not padded.
- out_Frame_Done <= in_Valid && x=IMG_WIDTH-1 && y=IMG_HEIGHT-1 (same cycle as the last out_Valid).
- Stall (in_Valid=0): x, y, window regs and LBs hold; out_Valid=0 next cycle; out_M* keep their last value.
- in_Sof with in_Valid mid-frame: resync. The pixel is treated as (0,0), counters restart, and no window is emitted until (2,2) of the new frame. Stale line-buffer data is never emitted because of the y>=2 gating.
- in_Sof without in_Valid is ignored.
- Reset mid-frame: as above. The next accepted pixel is (0,0) even without in_Sof.
- Row wrap: window regs are not cleared at line start. Windows at x=0 and x=1 contain previous-line columns but are suppressed by x>=2.
- Widths: x is clog2(IMG_WIDTH) bits, y is clog2(IMG_HEIGHT) bits; no arithmetic on pixel data.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=6, pixel = {8'h00, y, x}, continuous in_Valid, in_Sof on first pixel -> first out_Valid 1 clk after pixel (2,2): out_M0=72'h000000_000001_000002 rotated per packing, i.e. {P(2,0),P(1,0),P(0,0)} = 72'h000002000001000000, out_M1=72'h000102000101000100, out_M2=72'h000202000201000200, out_Center=24'h000101.
- Same frame -> exactly 24 out_Valid pulses ((8-2)*(6-2)). out_Frame_Done pulses once, coincident with the last window (centre 24'h000406). The next frame's first window again appears at pixel (2,2).
- Random in_Valid gaps (about 50% duty) on the same image -> identical sequence of out_M*/out_Center values as the gap-free run. out_Valid is never high on a cycle after a non-accept.
- in_Sof asserted at pixel (3,4) of frame 1 -> no out_Valid until new pixel (2,2). Windows after the resync contain only new-frame data.
- rst_n pulsed low asynchronously mid-line (between edges) -> all outputs 0 immediately. The next accepted pixel without in_Sof is (0,0); first window at (2,2).
- Minimum size IMG_WIDTH=3, IMG_HEIGHT=3 -> exactly one window per frame, centre P(1,1), with out_Frame_Done in the same cycle.
